boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15: instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, default 2**ADDR_W: largest accepted program length in words.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, 8: received UART byte.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle pulse; rx_data is valid in that cycle.
REQ-007 SHALL have port rx_ferr, input, 1: framing error, qualified by rx_valid.
REQ-008 SHALL have port tx_data, output, 8: byte to transmit.
REQ-009 SHALL have port tx_start, output, 1: one-cycle transmit request.
REQ-010 SHALL have port tx_busy, input, 1: the transmitter is sending.
REQ-011 SHALL have port imem_we, output, 1: instruction-memory write strobe.
REQ-012 SHALL have port imem_addr, output, ADDR_W: instruction word address.
REQ-013 SHALL have port imem_wdata, output, 32: instruction word.
REQ-014 SHALL have port boot_done, output, 1: program loaded; CPU may run and owns the UART.
REQ-015 SHALL have port err, output, 1: sticky load failure.

Function
REQ-016 SHALL implement the states S_HELLO, S_LEN, S_PROG, S_CSUM, S_ACK, S_DONE and S_ERR.
REQ-017 SHALL, in S_HELLO, pulse tx_start with tx_data=8'h99 on the first cycle tx_busy=0, then enter S_LEN on the next cycle.
REQ-018 SHALL drop every rx_valid byte received while in S_HELLO.
REQ-019 SHALL, in S_LEN, assemble 4 bytes little-endian into a 32-bit word count N.
REQ-020 SHALL, after the 4th length byte: go to S_ERR if N>MAX_WORDS; go to S_CSUM/S_ACK if N=0; otherwise go to S_PROG.
REQ-021 SHALL, in S_PROG, assemble each 4 bytes little-endian (first byte is bits 7:0) into imem_wdata.
REQ-022 SHALL assert imem_we for exactly one cycle, the cycle after the rx_valid carrying the 4th byte of each word.
REQ-023 SHALL drive imem_addr with the word index, starting at 0 and incrementing after each write.
REQ-024 SHALL leave S_PROG after N writes, for S_CSUM if BOOT_CHECKSUM_EN is defined and S_ACK otherwise.
REQ-025 SHALL, in S_ACK, pulse tx_start with 8'haa once tx_busy=0, then assert boot_done from the following cycle on.
REQ-026 SHALL treat rx_valid with rx_ferr=1 in S_LEN, S_PROG or S_CSUM as fatal: go to S_ERR and discard the partial word.
REQ-027 SHALL, in S_ERR, set err=1, pulse tx_start once with 8'hee when tx_busy=0, then hold with boot_done=0.
REQ-028 SHALL never assert tx_start while tx_busy=1.
REQ-029 SHALL keep tx_start low for at least one cycle after every pulse.
REQ-030 SHALL ignore all rx_valid bytes in S_DONE and S_ERR.

Reset
REQ-031 SHALL, on rstn=0, immediately set the state to S_HELLO and clear all counters, the byte shift register and the checksum.
REQ-032 SHALL hold these output values during reset: tx_start=0, tx_data=0, imem_we=0, imem_addr=0, imem_wdata=0, boot_done=0, err=0.
REQ-033 SHALL, when reset is applied mid-load, abandon the load and restart at S_HELLO; memory contents already written are left as they are.

Configuration
REQ-034 SHALL, with BOOT_CHECKSUM_EN defined, accumulate the XOR of all program bytes.
REQ-035 SHALL, with BOOT_CHECKSUM_EN defined, in S_CSUM take one byte: equal to the XOR goes to S_ACK, different goes to S_ERR.
REQ-036 SHALL, without BOOT_CHECKSUM_EN, omit S_CSUM and the checksum logic; no trailing byte is expected.

Structure
REQ-037 SHALL take the state enum and the constants BOOT_HELLO=8'h99, BOOT_ACK=8'haa and BOOT_NAK=8'hee from package boot_pkg.
REQ-038 SHALL instantiate sub-module boot_word_asm, a byte-to-32-bit little-endian assembler with a word-valid pulse, used for both the length and the program words.

Verification
REQ-039 SHALL verify: release reset -> exactly one tx_start with 8'h99, and no imem_we.
REQ-040 SHALL verify: length 02 00 00 00, then 13 00 00 00 93 00 10 00 -> writes addr0=32'h00000013 and addr1=32'h00100093, then 8'haa, then boot_done=1.
REQ-041 SHALL verify: length 00 00 00 00 -> no imem_we, 8'haa sent, boot_done=1.
REQ-042 SHALL verify: length MAX_WORDS+1 -> 8'hee sent, err=1, later bytes produce no writes.
REQ-043 SHALL verify: rx_ferr on the 6th byte -> S_ERR, err=1, no write of the partial word.
REQ-044 SHALL verify, with BOOT_CHECKSUM_EN: one word 01 02 03 04 with checksum 8'h04 -> 8'haa; with checksum 8'h05 -> 8'hee; and rstn pulsed mid-S_PROG -> 8'h99 re-sent and addr restarts at 0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
//   boot_state_e : loader FSM state encoding
//   BOOT_HELLO   : byte sent after reset to announce the loader
//   BOOT_ACK     : byte sent after a program loads successfully
//   BOOT_NAK     : byte sent once when a load fails
package boot_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [BYTE_W-1:0] BOOT_HELLO = 8'h99;
  localparam logic [BYTE_W-1:0] BOOT_ACK   = 8'haa;
  localparam logic [BYTE_W-1:0] BOOT_NAK   = 8'hee;

  typedef enum logic [2:0] {
    S_HELLO = 3'd0,
    S_LEN   = 3'd1,
    S_PROG  = 3'd2,
    S_CSUM  = 3'd3,
    S_ACK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } boot_state_e;

endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word assembler: collects four bytes little-endian (first byte lands
// in bits 7:0) and flags the word combinationally on the 4th byte.
//   clk, rstn    : clock, async active-low reset
//   clr          : synchronous restart of the byte count and partial word
//   byte_valid   : byte_data is valid this cycle
//   byte_data    : incoming byte
//   word_done_c  : high in the cycle of the 4th byte
//   word_c       : completed word (meaningful only when word_done_c=1)
module boot_word_asm
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_done_c,
  output logic [WORD_W-1:0] word_c
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;

  // New byte enters at the top; after four shifts the first byte sits at 7:0.
  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    word_c      = {byte_data, shift_q[WORD_W-1:BYTE_W]};
    word_done_c = 1'b0;
    if (clr) begin
      cnt_d   = 2'd0;
      shift_d = '0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = word_c;
      if (cnt_q == 2'd3) begin
        word_done_c = 1'b1;
        shift_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: announces itself, receives a little-endian word count and
// program words, writes them to instruction memory and acknowledges.
// Optional trailing XOR checksum byte when BOOT_CHECKSUM_EN is defined.
//   clk, rstn            : clock, async active-low reset
//   rx_data/valid/ferr   : received UART byte, strobe, framing error
//   tx_data/start, busy  : transmit byte, one-cycle request, transmitter busy
//   imem_we/addr/wdata   : instruction-memory write port
//   boot_done            : program loaded, CPU owns the UART
//   err                  : sticky load failure
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              boot_done,
  output logic              err
);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e S_AFTER_PROG = S_CSUM;
`else
  localparam boot_state_e S_AFTER_PROG = S_ACK;
`endif

  boot_state_e       state_q, state_d;
  logic [WORD_W-1:0] len_q, len_d;
  logic [WORD_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              boot_done_q, boot_done_d;
  logic              err_q, err_d;
  logic              nak_sent_q, nak_sent_d;
`ifdef BOOT_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  logic              asm_valid_c;
  logic              asm_clr_c;
  logic              word_done_c;
  logic [WORD_W-1:0] word_c;
  logic              ferr_c;
  logic              tx_ok_c;

  // Framing-error bytes never reach the assembler, so a partial word is dropped.
  assign ferr_c      = rx_valid && rx_ferr;
  assign asm_valid_c = rx_valid && !rx_ferr && (state_q == S_LEN || state_q == S_PROG);
  assign asm_clr_c   = (state_q == S_HELLO);
  // A new request needs an idle transmitter and a low cycle after any pulse.
  assign tx_ok_c     = !tx_busy && !tx_start_q;

  boot_word_asm u_word_asm (
    .clk         (clk),
    .rstn        (rstn),
    .clr         (asm_clr_c),
    .byte_valid  (asm_valid_c),
    .byte_data   (rx_data),
    .word_done_c (word_done_c),
    .word_c      (word_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_cnt_d    = wr_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    boot_done_d = boot_done_q;
    err_d       = err_q;
    nak_sent_d  = nak_sent_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    // Address advances right after each write strobe.
    if (we_q) addr_d = addr_q + ADDR_W'(1);

    case (state_q)
      S_HELLO: begin
        if (tx_ok_c) begin
          tx_start_d = 1'b1;
          tx_data_d  = BOOT_HELLO;
          state_d    = S_LEN;
        end
      end
      S_LEN: begin
        if (ferr_c) begin
          state_d = S_ERR;
        end else if (word_done_c) begin
          len_d = word_c;
          if (word_c > WORD_W'(MAX_WORDS)) state_d = S_ERR;
          else if (word_c == '0)           state_d = S_AFTER_PROG;
          else                             state_d = S_PROG;
        end
      end
      S_PROG: begin
        if (ferr_c) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (word_done_c) begin
            we_d     = 1'b1;
            wdata_d  = word_c;
            wr_cnt_d = wr_cnt_q + WORD_W'(1);
            if (wr_cnt_q + WORD_W'(1) == len_q) state_d = S_AFTER_PROG;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_ferr || rx_data != csum_q) state_d = S_ERR;
          else                              state_d = S_ACK;
        end
      end
`endif
      S_ACK: begin
        if (tx_ok_c) begin
          tx_start_d = 1'b1;
          tx_data_d  = BOOT_ACK;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        boot_done_d = 1'b1;
      end
      S_ERR: begin
        err_d = 1'b1;
        if (!nak_sent_q && tx_ok_c) begin
          tx_start_d = 1'b1;
          tx_data_d  = BOOT_NAK;
          nak_sent_d = 1'b1;
        end
      end
      default: begin
        state_d = S_HELLO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_HELLO;
      len_q       <= '0;
      wr_cnt_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      boot_done_q <= 1'b0;
      err_q       <= 1'b0;
      nak_sent_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      boot_done_q <= boot_done_d;
      err_q       <= err_d;
      nak_sent_q  <= nak_sent_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign boot_done  = boot_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: hello, program load, zero length, oversize
// length, framing error, reset mid-load and (with BOOT_CHECKSUM_EN) checksum.
module tb_boot_loader;

  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned MAX_WORDS = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ferr = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              boot_done;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Observed activity, accumulated by the monitor.
  int                tx_cnt = 0;
  int                we_cnt = 0;
  int                viol_cnt = 0;
  logic [7:0]        last_tx = 8'h00;
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [31:0]       wr_data_log[$];

  boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .boot_done  (boot_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (tx_start) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= tx_data;
      if (tx_busy) viol_cnt <= viol_cnt + 1;
    end
    if (imem_we) begin
      we_cnt <= we_cnt + 1;
      wr_addr_log.push_back(imem_addr);
      wr_data_log.push_back(imem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic f);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_ferr  = f;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    tx_busy  = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(3);
  endtask

  task automatic test_reset();
    int t0;
    @(negedge clk);
    rstn    = 1'b0;
    tx_busy = 1'b1;
    idle(2);
    checks++;
    if ({tx_start, tx_data, imem_we, imem_addr, imem_wdata, boot_done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b data=%h we=%b addr=%h wdata=%h done=%b err=%b, expected all 0",
               tx_start, tx_data, imem_we, imem_addr, imem_wdata, boot_done, err);
    end
    t0 = tx_cnt;
    rstn = 1'b1;
    idle(3);
    send_byte(8'h55, 1'b0);  // dropped while in hello
    idle(2);
    checks++;
    if (tx_cnt - t0 !== 0) begin
      errors++;
      $display("FAIL hello_waits_busy: got %0d tx pulses, expected 0", tx_cnt - t0);
    end
    tx_busy = 1'b0;
    idle(4);
    checks++;
    if (tx_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL hello_count: got %0d tx pulses, expected 1", tx_cnt - t0);
    end
    checks++;
    if (last_tx !== 8'h99) begin
      errors++;
      $display("FAIL hello_byte: got %h expected 99", last_tx);
    end
    checks++;
    if (we_cnt !== 0) begin
      errors++;
      $display("FAIL hello_no_write: got %0d writes expected 0", we_cnt);
    end
  endtask

  // Continues from test_reset without a new reset: the dropped 0x55 must not shift framing.
  task automatic test_program();
    int w0, n0, t0;
    w0 = we_cnt; n0 = wr_addr_log.size(); t0 = tx_cnt;
    send_word(32'd2);
    send_word(32'h00000013);
    send_word(32'h00100093);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h90, 1'b0);
`endif
    idle(4);
    checks++;
    if (we_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL prog_write_count: got %0d expected 2", we_cnt - w0);
    end
    checks++;
    if (wr_addr_log[n0] !== 15'd0 || wr_data_log[n0] !== 32'h00000013) begin
      errors++;
      $display("FAIL prog_word0: got addr=%h data=%h expected addr=0 data=00000013", wr_addr_log[n0], wr_data_log[n0]);
    end
    checks++;
    if (wr_addr_log[n0+1] !== 15'd1 || wr_data_log[n0+1] !== 32'h00100093) begin
      errors++;
      $display("FAIL prog_word1: got addr=%h data=%h expected addr=1 data=00100093", wr_addr_log[n0+1], wr_data_log[n0+1]);
    end
    checks++;
    if (tx_cnt - t0 !== 1 || last_tx !== 8'haa) begin
      errors++;
      $display("FAIL prog_ack: got %0d pulses last=%h expected 1 pulse aa", tx_cnt - t0, last_tx);
    end
    checks++;
    if (boot_done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL prog_done: got done=%b err=%b expected done=1 err=0", boot_done, err);
    end
    send_word(32'hdeadbeef);
    idle(2);
    checks++;
    if (we_cnt - w0 !== 2 || tx_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL done_ignores_rx: got %0d writes %0d pulses expected 2 and 1", we_cnt - w0, tx_cnt - t0);
    end
  endtask

  task automatic test_zero_len();
    int w0, t0;
    do_reset();
    w0 = we_cnt; t0 = tx_cnt;
    send_word(32'd0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    idle(4);
    checks++;
    if (we_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL zero_no_write: got %0d writes expected 0", we_cnt - w0);
    end
    checks++;
    if (tx_cnt - t0 !== 1 || last_tx !== 8'haa || boot_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_ack: got %0d pulses last=%h done=%b expected 1 aa 1", tx_cnt - t0, last_tx, boot_done);
    end
  endtask

  task automatic test_too_long();
    int w0, t0;
    do_reset();
    w0 = we_cnt; t0 = tx_cnt;
    send_word(32'(MAX_WORDS + 1));
    idle(4);
    checks++;
    if (tx_cnt - t0 !== 1 || last_tx !== 8'hee) begin
      errors++;
      $display("FAIL toolong_nak: got %0d pulses last=%h expected 1 ee", tx_cnt - t0, last_tx);
    end
    checks++;
    if (err !== 1'b1 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL toolong_err: got err=%b done=%b expected err=1 done=0", err, boot_done);
    end
    send_word(32'h12345678);
    send_word(32'h9abcdef0);
    idle(3);
    checks++;
    if (we_cnt - w0 !== 0 || tx_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL toolong_ignore: got %0d writes %0d pulses expected 0 and 1", we_cnt - w0, tx_cnt - t0);
    end
  endtask

  task automatic test_ferr();
    int w0, t0;
    do_reset();
    w0 = we_cnt; t0 = tx_cnt;
    send_word(32'd1);
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b1);  // 6th byte carries a framing error
    send_byte(8'hcc, 1'b0);
    send_byte(8'hdd, 1'b0);
    idle(4);
    checks++;
    if (we_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL ferr_no_write: got %0d writes expected 0", we_cnt - w0);
    end
    checks++;
    if (err !== 1'b1 || last_tx !== 8'hee || tx_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL ferr_err: got err=%b last=%h pulses=%0d expected 1 ee 1", err, last_tx, tx_cnt - t0);
    end
  endtask

  task automatic test_reset_midload();
    int n0, t0;
    do_reset();
    n0 = wr_addr_log.size();
    send_word(32'd2);
    send_word(32'hcafef00d);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    checks++;
    if (wr_addr_log.size() - n0 !== 1 || wr_data_log[n0] !== 32'hcafef00d) begin
      errors++;
      $display("FAIL midload_first_write: got %0d writes data=%h expected 1 cafef00d", wr_addr_log.size() - n0, wr_data_log[n0]);
    end
    t0 = tx_cnt;
    @(negedge clk);
    rstn = 1'b0;
    idle(1);
    checks++;
    if (imem_addr !== 15'd0 || boot_done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midload_in_reset: got addr=%h done=%b err=%b expected 0 0 0", imem_addr, boot_done, err);
    end
    rstn = 1'b1;
    idle(3);
    checks++;
    if (tx_cnt - t0 !== 1 || last_tx !== 8'h99) begin
      errors++;
      $display("FAIL midload_rehello: got %0d pulses last=%h expected 1 99", tx_cnt - t0, last_tx);
    end
    n0 = wr_addr_log.size();
    send_word(32'd1);
    send_word(32'h0badc0de);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'hb8, 1'b0);
`endif
    idle(4);
    checks++;
    if (wr_addr_log.size() - n0 !== 1 || wr_addr_log[n0] !== 15'd0 || wr_data_log[n0] !== 32'h0badc0de) begin
      errors++;
      $display("FAIL midload_restart_addr: got addr=%h data=%h expected 0 0badc0de", wr_addr_log[n0], wr_data_log[n0]);
    end
    checks++;
    if (last_tx !== 8'haa || boot_done !== 1'b1) begin
      errors++;
      $display("FAIL midload_ack: got last=%h done=%b expected aa 1", last_tx, boot_done);
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    int w0;
    do_reset();
    w0 = we_cnt;
    send_word(32'd1);
    send_word(32'h04030201);
    send_byte(8'h04, 1'b0);
    idle(4);
    checks++;
    if (we_cnt - w0 !== 1 || last_tx !== 8'haa || boot_done !== 1'b1) begin
      errors++;
      $display("FAIL csum_good: got writes=%0d last=%h done=%b expected 1 aa 1", we_cnt - w0, last_tx, boot_done);
    end
    do_reset();
    send_word(32'd1);
    send_word(32'h04030201);
    send_byte(8'h05, 1'b0);
    idle(4);
    checks++;
    if (last_tx !== 8'hee || err !== 1'b1 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL csum_bad: got last=%h err=%b done=%b expected ee 1 0", last_tx, err, boot_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_zero_len();
    test_too_long();
    test_ferr();
    test_reset_midload();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    checks++;
    if (viol_cnt !== 0) begin
      errors++;
      $display("FAIL tx_while_busy: got %0d pulses during busy expected 0", viol_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
